// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and stream-format constants for the instruction-memory loader
package imem_loader_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_CHK} state_t;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and instruction-memory write bus
//   in_valid/in_data/in_ready : boot-link byte stream (valid/ready)
//   mem_we/mem_waddr/mem_wdata: instruction-memory write port
//   master: boot link + memory side; slave: the loader
interface imem_loader_if #(parameter int INS_ADDRESS = 9, parameter int INS_W = 32);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;
    logic                   mem_we;
    logic [INS_ADDRESS-1:0] mem_waddr;
    logic [INS_W-1:0]       mem_wdata;
    modport master (output in_valid, in_data, input in_ready, mem_we, mem_waddr, mem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs bytes little-endian into a 32-bit word
//   clk, reset, clr : clock, sync reset, sync clear
//   push, in_byte   : accept in_byte into the next lane
//   word            : completed word assuming in_byte is the 4th byte
//   full            : the next push completes a word
module imem_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        full
);
    logic [23:0] sh;
    logic [1:0]  cnt;
    // Bytes enter at the top and shift down, so the first byte ends in [7:0].
    assign word = {in_byte, sh};
    assign full = cnt == 2'd3;
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sh  <= '0;
            cnt <= '0;
        end else if (push) begin
            sh  <= word[31:8];
            cnt <= cnt + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory while holding the core in reset
//   clk, reset : clock, synchronous active-high reset
//   start      : begin a load (honoured in IDLE or DONE only)
//   bus        : imem_loader_if.slave (byte stream in, memory write port out)
//   cpu_hold   : core held in reset during a load
//   busy       : load in progress
//   done       : load finished (sticky until start/reset)
//   error      : overflow or checksum mismatch (sticky until start/reset)
//   IMEM_LOADER_CHECKSUM_EN: adds a trailing XOR checksum byte checked in S_CHK
module imem_loader import imem_loader_pkg::*; #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         busy,
    output logic         done,
    output logic         error
);
    localparam int         WA  = INS_ADDRESS - 2;
    localparam logic [15:0] CAP = 16'(1 << WA);
    state_t                 state, state_n;
    logic [7:0]             n_lo;
    logic [WA:0]            n_words, wr_cnt;
    logic [INS_ADDRESS-1:0] waddr;
    logic [INS_W-1:0]       wdata;
    logic                   err, go, xfer, last, rdy, act;
    logic [15:0]            n_full;
    logic [31:0]            pk_word;
    logic                   pk_full;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif
    assign go     = start && (state == S_IDLE || state == S_DONE);
    assign xfer   = bus.in_valid && rdy;
    assign n_full = {bus.in_data, n_lo};
    assign last   = wr_cnt + 1'b1 == n_words;
    imem_word_packer u_packer (
        .clk(clk), .reset(reset), .clr(go), .push(state == S_DATA && xfer),
        .in_byte(bus.in_data), .word(pk_word), .full(pk_full)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        rdy     = state inside {S_LEN0, S_LEN1, S_DATA, S_CHK};
        act     = state inside {S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CHK};
        case (state)
            S_IDLE, S_DONE: state_n = go ? S_LEN0 : state;
            S_LEN0:         state_n = xfer ? S_LEN1 : state;
            S_LEN1:         state_n = !xfer ? state : n_full == 16'd0 ? S_DONE : S_DATA;
            S_DATA:         state_n = xfer && pk_full ? S_WRITE : state;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_WRITE:        state_n = last ? S_CHK : S_DATA;
            S_CHK:          state_n = xfer ? S_DONE : state;
`else
            S_WRITE:        state_n = last ? S_DONE : S_DATA;
`endif
            default:        state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            n_lo    <= '0;
            n_words <= '0;
            wr_cnt  <= '0;
            waddr   <= '0;
            wdata   <= '0;
            err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            if (go) begin
                err    <= 1'b0;
                waddr  <= '0;
                wr_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum   <= '0;
`endif
            end
            if (state == S_LEN0 && xfer) n_lo <= bus.in_data;
            // Oversized images are clipped so the address stops at the last word.
            if (state == S_LEN1 && xfer) begin
                n_words <= n_full > CAP ? CAP[WA:0] : n_full[WA:0];
                err     <= err | (n_full > CAP);
            end
            if (state == S_DATA && xfer && pk_full) wdata <= pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (state == S_DATA && xfer) csum <= csum ^ bus.in_data;
            if (state == S_CHK && xfer) err <= err | (bus.in_data != csum);
`endif
            // The address holds on the final word instead of stepping past capacity.
            if (state == S_WRITE) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (!last) waddr <= waddr + INS_ADDRESS'(BYTES_PER_WORD);
            end
        end
    end
    assign bus.in_ready  = rdy;
    assign bus.mem_we    = state == S_WRITE;
    assign bus.mem_waddr = waddr;
    assign bus.mem_wdata = wdata;
    assign cpu_hold      = act;
    assign busy          = act;
    assign done          = state == S_DONE;
    assign error         = err;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It takes a byte stream over a valid/ready handshake from a boot link such as a UART receiver, packs the bytes into 32-bit little-endian instruction words, and writes them sequentially into instruction memory starting at byte address 0. While a load is in progress it holds the CPU core in reset, so the PC only fetches a complete program image.

Parameters:
INS_ADDRESS, 9, byte-address width of the instruction memory; capacity is 2**(INS_ADDRESS-2) words.
INS_W, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader can accept a byte this cycle.
mem_we  output  1  instruction-memory write enable, one cycle per word.
mem_waddr  output  INS_ADDRESS  byte address of the write, word-aligned (bits [1:0] = 0).
mem_wdata  output  INS_W  assembled instruction word.
cpu_hold  output  1  holds the core in reset while a load is active.
busy  output  1  load in progress.
done  output  1  sticky: load finished; cleared by start or reset.
error  output  1  sticky: word count exceeded capacity (or checksum mismatch); cleared by start or reset.

Behaviour:
- Reset values: state IDLE, in_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, internal counters=0.
- Byte transfer occurs only when in_valid && in_ready; in_data is sampled on that edge.
- Stream format: 16-bit word count N (low byte first), then N words of 4 bytes each, least-significant byte first.
- IDLE: on start → LEN0, clear done/error, set address=0.
- LEN0: in_ready=1; on transfer latch N[7:0] → LEN1.
- LEN1: in_ready=1; on transfer latch N[15:8]. Then:
  - N=0 → DONE.
  - N > 2**(INS_ADDRESS-2) → set error, clip N to capacity → DATA. Excess bytes are not consumed.
  - Otherwise → DATA.
- DATA: in_ready=1; shift the byte into the packer at lane byte_cnt; on the 4th byte → WRITE.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle with the current mem_waddr and mem_wdata. Then address += 4 and words_written += 1. If words_written == N → DONE, else → DATA.
- DONE: done=1, busy=0, cpu_hold=0; start re-enters LEN0.
- cpu_hold=1 and busy=1 in LEN0, LEN1, DATA, WRITE (and CHK when present).
- Latency: the last byte of a word is accepted at edge t; mem_we is high in cycle t+1. Throughput is at most 4 bytes per 5 cycles.
- The address never wraps: clipping guarantees the final address is capacity*4-4.
- start while busy: ignored.
- in_valid low mid-word: the partial word is held indefinitely and no timeout applies.
- reset mid-load: return to IDLE, discard the partial word, release cpu_hold. Words already written stay in memory.
- mem_waddr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
IMEM_LOADER_CHECKSUM_EN:
- When defined, after the final WRITE the FSM enters CHK with in_ready=1 and accepts one byte. That byte must equal the XOR of all N*4 data bytes.
- On mismatch, set error; in either case → DONE.
- When not defined, there is no CHK state, no trailing byte, and WRITE goes directly to DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - state encoding constants: S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_CHK;
  - HDR_BYTES=2, BYTES_PER_WORD=4.
- Sub-module imem_word_packer: byte-lane shift register with a 2-bit byte counter. Inputs: clk, reset, clr, push, byte. Outputs: word, full. Cleared on start and on reset.

Test Plan:
- Header 0x03,0x00, then bytes 13 00 10 00 / 93 00 10 00 / 33 70 00 00 → writes 0x00100013@0x000, 0x00100093@0x004, 0x00007033@0x008; done=1, error=0, cpu_hold falls one cycle after the last write.
- Header 0x00,0x00 → no mem_we pulses; DONE reached two accepted bytes after start; cpu_hold high only during LEN0/LEN1.
- INS_ADDRESS=9, header N=200 (capacity 128) → error=1 after LEN1; exactly 128 writes, last at 0x1FC; in_ready=0 afterwards.
- Throttled stream (in_valid toggled every other cycle) with N=1 word 0x02B20263 → the same single write at 0x000; no write before the 4th byte.
- reset asserted after 2 data bytes, then a new start and a full 1-word load of 0xDEADBEEF → write 0xDEADBEEF@0x000 with no stale bytes; the start pulse during the second load is ignored.
- With IMEM_LOADER_CHECKSUM_EN: N=1 word bytes 01 02 04 08, checksum 0x0F → error=0; with checksum 0x0E → error=1; done=1 in both cases.
